mac_pipe_pe: RTL and testbench

MAC_PIPE_PE -- requirements
Module: mac_pipe_pe

---
 rtl/mac_pkg.sv | 30 +++
 rtl/mac_pipe_pe_if.sv | 38 +++
 rtl/mac_sat_add.sv | 52 +++++
 rtl/mac_pipe_pe.sv | 122 ++++++++++++
 tb/tb_mac_pipe_pe.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// ============================================================================
// Module   : mac_pkg
// Purpose  : Shared defaults, accumulator-width derivation and arithmetic
//            mode constants for the pipelined MAC processing element.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mac_pkg;

  // Default operand width of a processing element.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Arithmetic interpretation of operands and accumulator.
  localparam bit ARITH_UNSIGNED = 1'b0;
  localparam bit ARITH_SIGNED   = 1'b1;

  // Behaviour of the accumulator when a sum leaves its range.
  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  // Default accumulator width: room for the full product plus DATA_WIDTH
  // bits of headroom for repeated accumulation.
  function automatic int acc_width(input int data_width);
    return 3 * data_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_pipe_pe_if.sv
// ============================================================================
// Module   : mac_pipe_pe_if
// Purpose  : Operand/forwarding/result bundle of one MAC processing element.
//            The slave side is the PE, the master side is whatever feeds it.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mac_pipe_pe_if
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH)
);

  logic                  En;
  logic                  Clr;
  logic [DATA_WIDTH-1:0] Ain;
  logic [DATA_WIDTH-1:0] Bin;
  logic [DATA_WIDTH-1:0] Bout;
  logic                  EnOut;
  logic [ACC_WIDTH-1:0]  Couts;
  logic                  AccValid;
  logic                  Ovf;

  modport master (
    output En, Clr, Ain, Bin,
    input  Bout, EnOut, Couts, AccValid, Ovf
  );

  modport slave (
    input  En, Clr, Ain, Bin,
    output Bout, EnOut, Couts, AccValid, Ovf
  );

endinterface

`default_nettype wire

// File: rtl/mac_sat_add.sv
// ============================================================================
// Module   : mac_sat_add
// Purpose  : Combinational accumulator adder with overflow detection and an
//            optional clamp to the representable range.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_sat_add
  import mac_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter bit SIGNED   = ARITH_UNSIGNED,
  parameter bit SATURATE = MODE_WRAP
)(
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  output logic      [WIDTH-1:0] sum,
  output logic                  ovf
);

  localparam logic [WIDTH-1:0] c_umax = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   w_full;
  logic [WIDTH-1:0] w_raw;

  assign w_full = {1'b0, a} + {1'b0, b};
  assign w_raw  = w_full[WIDTH-1:0];

  // Detect overflow for the selected arithmetic and pick wrapped or clamped result.
  always_comb begin
    ovf = 1'b0;
    sum = w_raw;
    if (SIGNED == ARITH_SIGNED) begin
      // Only like-signed addends can leave the range; the result sign flips.
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_raw[WIDTH-1] != a[WIDTH-1]);
      if (ovf && (SATURATE == MODE_SAT)) begin
        sum = a[WIDTH-1] ? c_smin : c_smax;
      end
    end else begin
      ovf = w_full[WIDTH];
      if (ovf && (SATURATE == MODE_SAT)) begin
        sum = c_umax;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mac_pipe_pe.sv
// ============================================================================
// Module   : mac_pipe_pe
// Purpose  : Three-stage pipelined multiply-accumulate processing element for
//            a systolic array. S1 samples operands and tags, S2 holds the
//            product, S3 is the accumulator. Bin/En are forwarded after S1.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_pipe_pe
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH),
  parameter bit SIGNED     = ARITH_UNSIGNED,
  parameter bit SATURATE   = MODE_WRAP
)(
  input wire logic     clk,
  input wire logic     rst_n,
  mac_pipe_pe_if.slave bus
);

  localparam int c_prod_width = 2 * DATA_WIDTH;

  // S1
  logic [DATA_WIDTH-1:0]   r_s1_a;
  logic [DATA_WIDTH-1:0]   r_s1_b;
  logic                    r_s1_en;
  logic                    r_s1_clr;
  // S2
  logic [c_prod_width-1:0] r_s2_prod;
  logic                    r_s2_en;
  logic                    r_s2_clr;
  // S3
  logic [ACC_WIDTH-1:0]    r_acc;
  logic                    r_ovf;
  logic                    r_acc_valid;

  logic [c_prod_width-1:0] w_prod;
  logic [ACC_WIDTH-1:0]    w_prod_ext;
  logic [ACC_WIDTH-1:0]    w_acc_base;
  logic [ACC_WIDTH-1:0]    w_sum;
  logic                    w_add_ovf;

  // Operand interpretation decides both the multiply and the widening.
  if (SIGNED == ARITH_SIGNED) begin : g_signed_prod
    assign w_prod     = $signed(r_s1_a) * $signed(r_s1_b);
    assign w_prod_ext = ACC_WIDTH'($signed(r_s2_prod));
  end else begin : g_unsigned_prod
    assign w_prod     = r_s1_a * r_s1_b;
    assign w_prod_ext = ACC_WIDTH'(r_s2_prod);
  end

  // A clear travelling with a product turns the add into clear-and-load.
  assign w_acc_base = r_s2_clr ? '0 : r_acc;

  mac_sat_add #(
    .WIDTH    (ACC_WIDTH),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .a   (w_acc_base),
    .b   (w_prod_ext),
    .sum (w_sum),
    .ovf (w_add_ovf)
  );

  // S1: sample operands and tags; these registers also drive the forward path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_en  <= 1'b0;
      r_s1_clr <= 1'b0;
    end else begin
      r_s1_a   <= bus.Ain;
      r_s1_b   <= bus.Bin;
      r_s1_en  <= bus.En;
      r_s1_clr <= bus.Clr;
    end
  end

  // S2: register the product together with its tags so clears stay in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_prod <= '0;
      r_s2_en   <= 1'b0;
      r_s2_clr  <= 1'b0;
    end else begin
      r_s2_prod <= w_prod;
      r_s2_en   <= r_s1_en;
      r_s2_clr  <= r_s1_clr;
    end
  end

  // S3: accumulate, clear or hold; overflow is sticky until a clear arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_acc_valid <= 1'b0;
    end else begin
      r_acc_valid <= r_s2_en;
      if (r_s2_en) begin
        r_acc <= w_sum;
        r_ovf <= (r_ovf & ~r_s2_clr) | w_add_ovf;
      end else if (r_s2_clr) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.Bout     = r_s1_b;
  assign bus.EnOut    = r_s1_en;
  assign bus.Couts    = r_acc;
  assign bus.AccValid = r_acc_valid;
  assign bus.Ovf      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_pipe_pe.sv
// ============================================================================
// Module   : tb_mac_pipe_pe
// Purpose  : Directed self-checking bench for mac_pipe_pe in three builds:
//            default unsigned/wrap, 16-bit unsigned saturating, 16-bit
//            signed wrapping. All three share one stimulus stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mac_pipe_pe;
  import mac_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [7:0] a;
  logic [7:0] b;

  int checks;
  int failures;

  mac_pipe_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(24)) if0 ();
  mac_pipe_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) if1 ();
  mac_pipe_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) if2 ();

  assign if0.En = en;  assign if0.Clr = clr;  assign if0.Ain = a;  assign if0.Bin = b;
  assign if1.En = en;  assign if1.Clr = clr;  assign if1.Ain = a;  assign if1.Bin = b;
  assign if2.En = en;  assign if2.Clr = clr;  assign if2.Ain = a;  assign if2.Bin = b;

  mac_pipe_pe u_dut_def (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  mac_pipe_pe #(
    .DATA_WIDTH (8),
    .ACC_WIDTH  (16),
    .SIGNED     (ARITH_UNSIGNED),
    .SATURATE   (MODE_SAT)
  ) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  mac_pipe_pe #(
    .DATA_WIDTH (8),
    .ACC_WIDTH  (16),
    .SIGNED     (ARITH_SIGNED),
    .SATURATE   (MODE_WRAP)
  ) u_dut_sgn (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic [7:0] av, input logic [7:0] bv);
    en  = e;
    clr = c;
    a   = av;
    b   = bv;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic clear_all();
    drive(1'b0, 1'b1, 8'd0, 8'd0);
    step();
    idle();
    step();
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();
    step();
    step();

    // Reset state
    check("rst_couts",  32'(if0.Couts),    32'd0);
    check("rst_valid",  32'(if0.AccValid), 32'd0);
    check("rst_ovf",    32'(if0.Ovf),      32'd0);
    check("rst_bout",   32'(if0.Bout),     32'd0);
    check("rst_enout",  32'(if0.EnOut),    32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back unsigned accumulation: 12, 42, 98
    drive(1'b1, 1'b0, 8'd3, 8'd4);  step();
    check("b2b_valid_t", 32'(if0.AccValid), 32'd0);
    drive(1'b1, 1'b0, 8'd5, 8'd6);  step();
    check("b2b_valid_t1", 32'(if0.AccValid), 32'd0);
    drive(1'b1, 1'b0, 8'd7, 8'd8);  step();
    check("b2b_c0", 32'(if0.Couts), 32'd12);
    check("b2b_v0", 32'(if0.AccValid), 32'd1);
    idle(); step();
    check("b2b_c1", 32'(if0.Couts), 32'd42);
    check("b2b_v1", 32'(if0.AccValid), 32'd1);
    step();
    check("b2b_c2", 32'(if0.Couts), 32'd98);
    check("b2b_v2", 32'(if0.AccValid), 32'd1);
    step();
    check("b2b_v3", 32'(if0.AccValid), 32'd0);
    check("hold_c", 32'(if0.Couts), 32'd98);

    // Forwarding of Bin/En, one edge later
    drive(1'b1, 1'b0, 8'd0, 8'hA5); step();
    check("fwd_bout",  32'(if0.Bout),  32'hA5);
    check("fwd_enout", 32'(if0.EnOut), 32'd1);
    idle(); step();
    check("fwd_enout0", 32'(if0.EnOut), 32'd0);
    step();
    check("fwd_acc_hold", 32'(if0.Couts), 32'd98);

    // Pure clear zeroes without a valid pulse
    drive(1'b0, 1'b1, 8'd0, 8'd0); step();
    idle(); step();
    check("clr_pending", 32'(if0.Couts), 32'd98);
    step();
    check("clr_couts", 32'(if0.Couts),    32'd0);
    check("clr_valid", 32'(if0.AccValid), 32'd0);

    // Clear ordering: 4 then clear-and-load 9
    drive(1'b1, 1'b0, 8'd2, 8'd2); step();
    drive(1'b1, 1'b1, 8'd3, 8'd3); step();
    idle(); step();
    check("ord_c0", 32'(if0.Couts), 32'd4);
    step();
    check("ord_c1", 32'(if0.Couts), 32'd9);
    check("ord_v1", 32'(if0.AccValid), 32'd1);
    check("ord_ovf", 32'(if0.Ovf), 32'd0);

    // Saturation on the 16-bit unsigned build
    clear_all();
    drive(1'b1, 1'b0, 8'd255, 8'd255); step();
    drive(1'b1, 1'b0, 8'd255, 8'd255); step();
    idle(); step();
    check("sat_c0",   32'(if1.Couts), 32'd65025);
    check("sat_ovf0", 32'(if1.Ovf),   32'd0);
    step();
    check("sat_c1",   32'(if1.Couts), 32'd65535);
    check("sat_ovf1", 32'(if1.Ovf),   32'd1);
    step();
    check("sat_ovf_hold", 32'(if1.Ovf), 32'd1);
    clear_all();
    check("sat_clr_c",   32'(if1.Couts), 32'd0);
    check("sat_clr_ovf", 32'(if1.Ovf),   32'd0);

    // Signed wrap on the 16-bit signed build: (-128)*(-128) twice
    drive(1'b1, 1'b0, 8'h80, 8'h80); step();
    drive(1'b1, 1'b0, 8'h80, 8'h80); step();
    idle(); step();
    check("sgn_c0",   32'(if2.Couts), 32'h4000);
    check("sgn_ovf0", 32'(if2.Ovf),   32'd0);
    step();
    check("sgn_c1",   32'(if2.Couts), 32'h8000);
    check("sgn_ovf1", 32'(if2.Ovf),   32'd1);

    // Signed negative product: 0 + (-2)*3 = -6
    clear_all();
    drive(1'b1, 1'b0, 8'hFE, 8'd3); step();
    idle(); step(); step();
    check("sgn_neg", 32'(if2.Couts), 32'hFFFA);

    // Reset with two pairs in flight
    drive(1'b1, 1'b0, 8'd3, 8'd4); step();
    drive(1'b1, 1'b0, 8'd5, 8'd6); step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_couts", 32'(if0.Couts),    32'd0);
    check("arst_bout",  32'(if0.Bout),     32'd0);
    check("arst_enout", 32'(if0.EnOut),    32'd0);
    check("arst_valid", 32'(if0.AccValid), 32'd0);
    check("arst_sgn_c", 32'(if2.Couts),    32'd0);
    idle();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_valid", 32'(if0.AccValid), 32'd0);
      check("post_rst_couts", 32'(if0.Couts),    32'd0);
    end

    // First result after reset appears two edges after sampling
    drive(1'b1, 1'b0, 8'd2, 8'd3); step();
    idle(); step();
    check("post_rst_t1", 32'(if0.AccValid), 32'd0);
    step();
    check("post_rst_c", 32'(if0.Couts),    32'd6);
    check("post_rst_v", 32'(if0.AccValid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
